// File: rtl/point_test_pkg.sv
// Shared definitions for the point-test sideband arbiter: widths, message codes,
// FSM state encoding and the requester-selection helper.
package point_test_pkg;

   localparam int MSG_W_DEF  = 4;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [3:0] {
      MSG_NONE      = 4'b0000,
      TEST_REQ      = 4'b0001,
      TEST_RESP     = 4'b0010,
      LFSR_CLR_REQ  = 4'b0011,
      LFSR_CLR_RESP = 4'b0100,
      RESULT_REQ    = 4'b0101,
      RESULT_RESP   = 4'b0110,
      END_REQ       = 4'b0111,
      END_RESP      = 4'b1000
   } sb_msg_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_LOW = 2'd2,
      ST_DONE     = 2'd3
   } arb_state_e;

   // One-hot requester identity, bit 0 = TX, bit 1 = RX.
   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_TX   = 2'b01;
   localparam logic [1:0] GRANT_RX   = 2'b10;

   // On contention, round-robin hands the channel to whoever was not served last.
   function automatic logic [1:0] pick_winner(input logic       valid_tx,
                                              input logic       valid_rx,
                                              input logic       rr_en,
                                              input logic [1:0] last_grant);
      logic [1:0] result;
      result = GRANT_NONE;
      if (valid_tx && valid_rx)
         result = (rr_en && (last_grant == GRANT_TX)) ? GRANT_RX : GRANT_TX;
      else if (valid_tx)
         result = GRANT_TX;
      else if (valid_rx)
         result = GRANT_RX;
      return result;
   endfunction

endpackage

// File: rtl/point_test_sb_arbiter_if.sv
// Bundle of the two requester channels plus the serializer-side handshake.
// Handshake: a requester holds valid (level) until it sees the release pulse;
// the arbiter holds o_sb_valid until i_sb_busy is sampled high, and the message
// is complete when i_sb_busy falls.
interface point_test_sb_arbiter_if #(
   parameter int MSG_W  = 4,
   parameter int DATA_W = 16
);
   logic              i_valid_tx;
   logic [MSG_W-1:0]  i_sideband_message_tx;
   logic [DATA_W-1:0] i_sideband_data_tx;
   logic              i_valid_rx;
   logic [MSG_W-1:0]  i_sideband_message_rx;
   logic [DATA_W-1:0] i_sideband_data_rx;
   logic              i_sb_busy;
   logic              o_sb_valid;
   logic [MSG_W-1:0]  o_sb_msg;
   logic [DATA_W-1:0] o_sb_data;
   logic              o_grant_tx;
   logic              o_grant_rx;
   logic              o_busy_negedge_detected;
   logic              o_timeout;

   modport slave (
      input  i_valid_tx, i_sideband_message_tx, i_sideband_data_tx,
      input  i_valid_rx, i_sideband_message_rx, i_sideband_data_rx,
      input  i_sb_busy,
      output o_sb_valid, o_sb_msg, o_sb_data, o_grant_tx, o_grant_rx,
      output o_busy_negedge_detected, o_timeout
   );

   modport master (
      output i_valid_tx, i_sideband_message_tx, i_sideband_data_tx,
      output i_valid_rx, i_sideband_message_rx, i_sideband_data_rx,
      output i_sb_busy,
      input  o_sb_valid, o_sb_msg, o_sb_data, o_grant_tx, o_grant_rx,
      input  o_busy_negedge_detected, o_timeout
   );
endinterface

// File: rtl/point_test_sb_arbiter_req_select.sv
// Combinational winner selection between the TX and RX point-test requesters.
module pt_sb_req_select
   import point_test_pkg::*;
#(
   parameter int RR_EN = 0
) (
   input  logic       i_valid_tx,
   input  logic       i_valid_rx,
   input  logic [1:0] i_last_grant,
   output logic [1:0] o_pick
);
   localparam logic RR_ON = (RR_EN != 0);

   assign o_pick = pick_winner(i_valid_tx, i_valid_rx, RR_ON, i_last_grant);

endmodule

// File: rtl/point_test_sb_arbiter.sv
// Arbitrates the shared sideband channel between the TX and RX point-test FSMs,
// forwards the winner's message and releases both FSMs when busy falls or times out.
module point_test_sb_arbiter
   import point_test_pkg::*;
#(
   parameter int MSG_W       = MSG_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 1024,
   parameter int RR_EN       = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   point_test_sb_arbiter_if.slave   sb,
   output arb_state_e               o_dbg_state,
   output logic [1:0]               o_dbg_last_grant
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic [1:0]        w_pick;
   logic [1:0]        r_grant;
   logic [1:0]        r_last_grant;
   logic [MSG_W-1:0]  r_msg;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy;
   logic              r_timeout;
   logic              w_req_held;
   logic              w_negedge;
   logic              w_cnt_last;
   logic              w_load;
   logic              w_fire_timeout;

   pt_sb_req_select #(.RR_EN(RR_EN)) u_req_select (
      .i_valid_tx   (sb.i_valid_tx),
      .i_valid_rx   (sb.i_valid_rx),
      .i_last_grant (r_last_grant),
      .o_pick       (w_pick)
   );

   assign w_req_held = (r_grant[0] & sb.i_valid_tx) | (r_grant[1] & sb.i_valid_rx);
   assign w_negedge  = r_busy & ~sb.i_sb_busy;
   assign w_cnt_last = (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // A dropped request beats the timeout; a busy negedge beats the timeout.
   always_comb begin
      w_state_nxt    = r_state;
      w_load         = 1'b0;
      w_fire_timeout = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick != GRANT_NONE) begin
               w_state_nxt = ST_SEND;
               w_load      = 1'b1;
            end
         end
         ST_SEND: begin
            if (!w_req_held) begin
               w_state_nxt = ST_IDLE;
            end else if (w_cnt_last) begin
               w_state_nxt    = ST_DONE;
               w_fire_timeout = 1'b1;
            end else if (sb.i_sb_busy) begin
               w_state_nxt = ST_WAIT_LOW;
            end
         end
         ST_WAIT_LOW: begin
            if (w_negedge) begin
               w_state_nxt = ST_DONE;
            end else if (w_cnt_last) begin
               w_state_nxt    = ST_DONE;
               w_fire_timeout = 1'b1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant      <= GRANT_NONE;
         r_last_grant <= GRANT_NONE;
         r_msg        <= '0;
         r_data       <= '0;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_busy    <= sb.i_sb_busy;
         r_timeout <= w_fire_timeout;
         if (w_load) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_msg        <= w_pick[0] ? sb.i_sideband_message_tx : sb.i_sideband_message_rx;
            r_data       <= w_pick[0] ? sb.i_sideband_data_tx    : sb.i_sideband_data_rx;
            r_cnt        <= '0;
         end else begin
            if (w_state_nxt inside {ST_IDLE, ST_DONE})
               r_grant <= GRANT_NONE;
            if ((r_state inside {ST_SEND, ST_WAIT_LOW}) && (r_cnt != CNT_MAX))
               r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign sb.o_sb_valid              = (r_state == ST_SEND);
   assign sb.o_sb_msg                = r_msg;
   assign sb.o_sb_data               = r_data;
   assign sb.o_grant_tx              = r_grant[0];
   assign sb.o_grant_rx              = r_grant[1];
   assign sb.o_busy_negedge_detected = (r_state == ST_DONE);
   assign sb.o_timeout               = r_timeout;
   assign o_dbg_state                = r_state;
   assign o_dbg_last_grant           = r_last_grant;

endmodule

// File: tb/tb_point_test_sb_arbiter.sv
// Bench for point_test_sb_arbiter: a fixed-priority and a round-robin instance share
// one stimulus stream and are each compared against a transaction-level model.
module tb_point_test_sb_arbiter;
   import point_test_pkg::*;

   localparam int MSG_W  = 4;
   localparam int DATA_W = 16;
   localparam int TMO    = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              in_rst  = 1'b1;
   logic              in_vtx  = 1'b0;
   logic              in_vrx  = 1'b0;
   logic              in_busy = 1'b0;
   logic [MSG_W-1:0]  in_mtx  = '0;
   logic [MSG_W-1:0]  in_mrx  = '0;
   logic [DATA_W-1:0] in_dtx  = '0;
   logic [DATA_W-1:0] in_drx  = '0;

   point_test_sb_arbiter_if #(.MSG_W(MSG_W), .DATA_W(DATA_W)) bus_fp ();
   point_test_sb_arbiter_if #(.MSG_W(MSG_W), .DATA_W(DATA_W)) bus_rr ();

   assign bus_fp.i_valid_tx = in_vtx;  assign bus_rr.i_valid_tx = in_vtx;
   assign bus_fp.i_valid_rx = in_vrx;  assign bus_rr.i_valid_rx = in_vrx;
   assign bus_fp.i_sb_busy  = in_busy; assign bus_rr.i_sb_busy  = in_busy;
   assign bus_fp.i_sideband_message_tx = in_mtx; assign bus_rr.i_sideband_message_tx = in_mtx;
   assign bus_fp.i_sideband_message_rx = in_mrx; assign bus_rr.i_sideband_message_rx = in_mrx;
   assign bus_fp.i_sideband_data_tx    = in_dtx; assign bus_rr.i_sideband_data_tx    = in_dtx;
   assign bus_fp.i_sideband_data_rx    = in_drx; assign bus_rr.i_sideband_data_rx    = in_drx;

   arb_state_e dbg_fp, dbg_rr;
   logic [1:0] lg_fp, lg_rr;

   point_test_sb_arbiter #(.MSG_W(MSG_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO), .RR_EN(0)) u_dut_fp (
      .clk(clk), .rst(in_rst), .sb(bus_fp), .o_dbg_state(dbg_fp), .o_dbg_last_grant(lg_fp));
   point_test_sb_arbiter #(.MSG_W(MSG_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO), .RR_EN(1)) u_dut_rr (
      .clk(clk), .rst(in_rst), .sb(bus_rr), .o_dbg_state(dbg_rr), .o_dbg_last_grant(lg_rr));

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [MSG_W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Per instance: who owns the channel (0 none, 1 TX, 2 RX), whether the serializer
   // has accepted the message, cycles spent on it, and the release/timeout pulses.
   int               m_owner[2];
   bit               m_sent[2];
   bit               m_prev_busy[2];
   int               m_elapsed[2];
   bit               m_rel[2];
   bit               m_tmo[2];
   int               m_last[2];
   logic [MSG_W-1:0] m_msg[2];
   logic [DATA_W-1:0] m_data[2];

   task automatic model_step(input int i, input bit rr);
      int w;
      bit held;
      bit expired;
      if (in_rst) begin
         m_owner[i] = 0; m_sent[i] = 0; m_prev_busy[i] = 0; m_elapsed[i] = 0;
         m_rel[i] = 0; m_tmo[i] = 0; m_last[i] = 0; m_msg[i] = '0; m_data[i] = '0;
         if (i == 0) exp_q.delete();
         return;
      end
      if (m_rel[i]) begin
         m_rel[i] = 0;
         m_tmo[i] = 0;
      end else if (m_owner[i] == 0) begin
         w = 0;
         if (in_vtx && in_vrx) w = (rr && m_last[i] == 1) ? 2 : 1;
         else if (in_vtx)      w = 1;
         else if (in_vrx)      w = 2;
         if (w != 0) begin
            m_owner[i] = w; m_last[i] = w; m_sent[i] = 0; m_elapsed[i] = 0;
            m_msg[i]  = (w == 1) ? in_mtx : in_mrx;
            m_data[i] = (w == 1) ? in_dtx : in_drx;
         end
      end else begin
         held    = (m_owner[i] == 1) ? in_vtx : in_vrx;
         expired = (m_elapsed[i] == TMO - 1);
         if (!m_sent[i] && !held) begin
            m_owner[i] = 0;
         end else if (m_sent[i] && m_prev_busy[i] && !in_busy) begin
            m_owner[i] = 0; m_rel[i] = 1;
         end else if (expired) begin
            m_owner[i] = 0; m_rel[i] = 1; m_tmo[i] = 1;
         end else begin
            if (!m_sent[i] && in_busy) m_sent[i] = 1;
            m_elapsed[i]++;
         end
         if (m_rel[i] && i == 0) exp_q.push_back(m_msg[i]);
      end
      m_prev_busy[i] = in_busy;
   endtask

   task automatic check_dut(input int i);
      logic v, gt, gr, pl, to;
      logic [MSG_W-1:0] ms;
      logic [DATA_W-1:0] da;
      string tag;
      if (i == 0) begin
         v = bus_fp.o_sb_valid; gt = bus_fp.o_grant_tx; gr = bus_fp.o_grant_rx;
         pl = bus_fp.o_busy_negedge_detected; to = bus_fp.o_timeout;
         ms = bus_fp.o_sb_msg; da = bus_fp.o_sb_data; tag = "fp";
      end else begin
         v = bus_rr.o_sb_valid; gt = bus_rr.o_grant_tx; gr = bus_rr.o_grant_rx;
         pl = bus_rr.o_busy_negedge_detected; to = bus_rr.o_timeout;
         ms = bus_rr.o_sb_msg; da = bus_rr.o_sb_data; tag = "rr";
      end
      chk({tag, "_valid"},   32'(v),  32'(m_owner[i] != 0 && !m_sent[i]));
      chk({tag, "_grant_tx"}, 32'(gt), 32'(m_owner[i] == 1));
      chk({tag, "_grant_rx"}, 32'(gr), 32'(m_owner[i] == 2));
      chk({tag, "_release"}, 32'(pl), 32'(m_rel[i]));
      chk({tag, "_timeout"}, 32'(to), 32'(m_tmo[i]));
      chk({tag, "_msg"},     32'(ms), 32'(m_msg[i]));
      chk({tag, "_data"},    32'(da), 32'(m_data[i]));
   endtask

   task automatic step();
      @(posedge clk);
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      #1;
      check_dut(0);
      check_dut(1);
      if (bus_fp.o_busy_negedge_detected) begin
         if (exp_q.size() == 0) chk("fp_release_queue", 32'(bus_fp.o_sb_msg), 32'hffff_ffff);
         else                   chk("fp_release_msg", 32'(bus_fp.o_sb_msg), 32'(exp_q.pop_front()));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic vtx, input logic vrx, input logic busy,
                        input logic [MSG_W-1:0] mtx, input logic [MSG_W-1:0] mrx);
      in_rst = r; in_vtx = vtx; in_vrx = vrx; in_busy = busy; in_mtx = mtx; in_mrx = mrx;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      step();
      in_rst = 1'b0;
   endtask

   // ---------------- directed table (fixed-priority instance) ----------------
   typedef struct packed {
      logic rst, vtx, vrx, busy;
      logic [MSG_W-1:0] mtx, mrx;
      logic v, gtx, grx, pls, tmo;
      logic [MSG_W-1:0] msg;
   } vec_t;

   vec_t vt[19];

   initial begin
      // TX alone: request, busy two cycles later for five cycles, then release.
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
      vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
      for (int k = 3; k <= 7; k++)
         vt[k] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1};
      // Both request: TX (0011) first, RX (0010) after the DONE/IDLE gap.
      vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3};
      vt[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3};
      vt[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3};
      vt[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3};
      vt[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2};
      vt[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2};
      vt[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2};
      vt[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2};
      vt[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2};

      in_dtx = 16'h0000;
      in_drx = 16'h2222;
      for (int k = 0; k < 19; k++) begin
         drive(vt[k].rst, vt[k].vtx, vt[k].vrx, vt[k].busy, vt[k].mtx, vt[k].mrx);
         step();
         chk($sformatf("tbl%0d_valid", k),    32'(bus_fp.o_sb_valid), 32'(vt[k].v));
         chk($sformatf("tbl%0d_grant_tx", k), 32'(bus_fp.o_grant_tx), 32'(vt[k].gtx));
         chk($sformatf("tbl%0d_grant_rx", k), 32'(bus_fp.o_grant_rx), 32'(vt[k].grx));
         chk($sformatf("tbl%0d_release", k),  32'(bus_fp.o_busy_negedge_detected), 32'(vt[k].pls));
         chk($sformatf("tbl%0d_timeout", k),  32'(bus_fp.o_timeout), 32'(vt[k].tmo));
         chk($sformatf("tbl%0d_msg", k),      32'(bus_fp.o_sb_msg), 32'(vt[k].msg));
      end

      // Round robin under repeated contention: TX, RX, TX.
      do_reset();
      for (int r = 0; r < 3; r++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, TEST_REQ, TEST_RESP);
         step();
         chk($sformatf("rr%0d_grant_tx", r), 32'(bus_rr.o_grant_tx), 32'(r % 2 == 0));
         chk($sformatf("rr%0d_grant_rx", r), 32'(bus_rr.o_grant_rx), 32'(r % 2 == 1));
         chk($sformatf("rr%0d_last", r), 32'(lg_rr), (r % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("fp%0d_grant_tx", r), 32'(bus_fp.o_grant_tx), 32'h1);
         in_busy = 1'b1; step();
         in_busy = 1'b0; step();
         chk($sformatf("rr%0d_release", r), 32'(bus_rr.o_busy_negedge_detected), 32'h1);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      step();

      // Busy never rises: forced release 16 cycles after the grant.
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0, END_REQ, '0);
      step();
      for (int c = 1; c < TMO; c++) step();
      chk("tmo_before_pulse", 32'(bus_fp.o_busy_negedge_detected), 32'h0);
      step();
      chk("tmo_timeout",  32'(bus_fp.o_timeout), 32'h1);
      chk("tmo_release",  32'(bus_fp.o_busy_negedge_detected), 32'h1);
      chk("tmo_valid",    32'(bus_fp.o_sb_valid), 32'h0);
      step();
      chk("tmo_idle", 32'(dbg_fp), 32'(ST_IDLE));
      in_vtx = 1'b0; step();

      // RX withdraws before busy: silent abort, then a normal TX transfer.
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, RESULT_RESP);
      step();
      chk("abort_grant_rx", 32'(bus_fp.o_grant_rx), 32'h1);
      step();
      in_vrx = 1'b0; step();
      chk("abort_valid",   32'(bus_fp.o_sb_valid), 32'h0);
      chk("abort_release", 32'(bus_fp.o_busy_negedge_detected), 32'h0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, RESULT_REQ, '0);
      step();
      chk("after_abort_grant_tx", 32'(bus_fp.o_grant_tx), 32'h1);
      chk("after_abort_msg", 32'(bus_fp.o_sb_msg), 32'(RESULT_REQ));
      in_busy = 1'b1; step();
      in_busy = 1'b0; step();
      chk("after_abort_release", 32'(bus_fp.o_busy_negedge_detected), 32'h1);
      step();
      in_vtx = 1'b0; step();

      // Reset during WAIT_LOW: everything clears, later busy fall is ignored.
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0, LFSR_CLR_REQ, '0);
      step();
      in_busy = 1'b1; step();
      chk("rst_mid_state", 32'(dbg_fp), 32'(ST_WAIT_LOW));
      in_rst = 1'b1; step();
      chk("rst_mid_idle",  32'(dbg_fp), 32'(ST_IDLE));
      chk("rst_mid_msg",   32'(bus_fp.o_sb_msg), 32'h0);
      chk("rst_mid_grant", 32'(bus_fp.o_grant_tx), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
      step();
      in_busy = 1'b0; step();
      chk("rst_mid_no_pulse", 32'(bus_fp.o_busy_negedge_detected), 32'h0);

      // Random traffic against the model, both instances.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         in_rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 9) == 0) in_vtx = ~in_vtx;
         if ($urandom_range(0, 9) == 0) in_vrx = ~in_vrx;
         if ($urandom_range(0, 7) == 0) in_busy = ~in_busy;
         in_mtx = MSG_W'($urandom_range(1, 8));
         in_mrx = MSG_W'($urandom_range(1, 8));
         in_dtx = DATA_W'($urandom);
         in_drx = DATA_W'($urandom);
         step();
      end

      // ---------------- report ----------------
      chk("release_queue_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
